// File: rtl/block_mover.sv
`default_nettype none
// ============================================================================
//  Module      : block_mover
//  Description : Sweeps a multi-cell block horizontally across one row of the
//                VGA grid. The row is chosen by the level, and so is the speed.
//                The block either bounces between the edges or wraps from the
//                right edge back to x=0. When the player presses stop, the
//                block's position is latched.
//                Drives x/y/colour to the draw/erase datapath and the stop
//                position to the stack-overlap logic.
//  Ports       :
//    clk                 : system clock
//    reset_load          : asynchronous active-low reset
//    tick                : one-cycle timebase pulse
//    start               : begin sweeping (sampled in IDLE only)
//    stop                : lock the block (sampled in MOVE only)
//    level_in            : current level, 0 = bottom row
//    block_cells         : block width in cells, clamped to 1..MAX_CELLS
//    colour_in           : draw colour
//    colour_erase_enable : force colour to black
//    x, y                : block left-edge pixel / row top pixel
//    colour              : output colour
//    horizontal          : direction, 1 = right, 0 = left
//    done_load           : one-cycle pulse when new x/y first appear
//    stopped_valid       : one-cycle pulse when the block locks
//    stopped_x           : x at the last lock
//    busy                : high while moving
//    top_reached         : level row lies above the screen, start refused
//  Revision    : 1.0 - initial release
// ============================================================================
module block_mover #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int STEP        = 4,
  parameter int MAX_CELLS   = 4,
  parameter int LEVEL_W     = 6,
  parameter int BASE_PERIOD = 8,
  parameter int WRAP        = 0
) (
  input  logic               clk,
  input  logic               reset_load,
  input  logic               tick,
  input  logic               start,
  input  logic               stop,
  input  logic [LEVEL_W-1:0] level_in,
  input  logic [2:0]         block_cells,
  input  logic [2:0]         colour_in,
  input  logic               colour_erase_enable,
  output logic [7:0]         x,
  output logic [6:0]         y,
  output logic [2:0]         colour,
  output logic               horizontal,
  output logic               done_load,
  output logic               stopped_valid,
  output logic [7:0]         stopped_x,
  output logic               busy,
  output logic               top_reached
);

  // The period never exceeds BASE_PERIOD, so this width holds it.
  localparam int c_CNT_W = $clog2(BASE_PERIOD + 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
  localparam logic [7:0]         c_STEP8 = 8'(STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [7:0]           r_x, w_x_nxt;
  logic [6:0]           r_y, w_y_nxt;
  logic                 r_h, w_h_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [c_CNT_W-1:0]   r_period, w_period_nxt;
  logic [7:0]           r_rlim, w_rlim_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_sv, w_sv_nxt;
  logic [7:0]           r_sx, w_sx_nxt;
  logic                 r_top;

  // Geometry and speed are computed at 16 bits so that no intermediate term
  // can overflow, whatever the level.
  logic [15:0]          w_lvl16;
  logic                 w_top;
  logic [15:0]          w_y16;
  logic [2:0]           w_cells;
  logic [15:0]          w_rlim16;
  logic [15:0]          w_period16;
  logic                 w_due;
  logic [7:0]           w_mv_x;
  logic                 w_mv_h;

  always_comb begin
    w_lvl16    = 16'(level_in);
    w_top      = (w_lvl16 + 16'd1) > 16'(SCREEN_H / STEP);
    w_y16      = 16'(SCREEN_H) - 16'(STEP) * (w_lvl16 + 16'd1);
    if (block_cells == 3'd0)
      w_cells = 3'd1;
    else if (block_cells > 3'(MAX_CELLS))
      w_cells = 3'(MAX_CELLS);
    else
      w_cells = block_cells;
    w_rlim16   = 16'(SCREEN_W) - 16'(STEP) * 16'(w_cells);
    w_period16 = (16'(BASE_PERIOD) > w_lvl16) ? (16'(BASE_PERIOD) - w_lvl16) : 16'd1;
    w_due      = tick && (r_cnt == (r_period - c_ONE));
  end

  // Position and direction after one move.
  always_comb begin
    w_mv_x = r_x;
    w_mv_h = r_h;
    if (r_rlim == 8'd0) begin
      // Block spans the whole screen: there is nowhere to go.
      w_mv_x = r_x;
      w_mv_h = r_h;
    end else if (WRAP != 0) begin
      w_mv_h = 1'b1;
      w_mv_x = (r_x == r_rlim) ? 8'd0 : (r_x + c_STEP8);
    end else if (r_h) begin
      if (r_x == r_rlim) begin
        w_mv_h = 1'b0;
        w_mv_x = r_rlim - c_STEP8;
      end else begin
        w_mv_x = r_x + c_STEP8;
      end
    end else begin
      if (r_x == 8'd0) begin
        w_mv_h = 1'b1;
        w_mv_x = c_STEP8;
      end else begin
        w_mv_x = r_x - c_STEP8;
      end
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_h_nxt      = r_h;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period;
    w_rlim_nxt   = r_rlim;
    w_done_nxt   = 1'b0;
    w_sv_nxt     = 1'b0;
    w_sx_nxt     = r_sx;
    case (r_state)
      S_IDLE: begin
        if (start && !w_top) begin
          w_state_nxt  = S_MOVE;
          w_x_nxt      = 8'd0;
          w_h_nxt      = 1'b1;
          w_y_nxt      = 7'(w_y16);
          w_cnt_nxt    = '0;
          w_period_nxt = c_CNT_W'(w_period16);
          w_rlim_nxt   = 8'(w_rlim16);
          w_done_nxt   = 1'b1;
        end
      end
      S_MOVE: begin
        // A stop beats a move that falls due in the same cycle.
        if (stop) begin
          w_state_nxt = S_LOCK;
          w_sv_nxt    = 1'b1;
          w_sx_nxt    = r_x;
        end else if (tick) begin
          if (w_due) begin
            w_cnt_nxt  = '0;
            w_x_nxt    = w_mv_x;
            w_h_nxt    = w_mv_h;
            w_done_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + c_ONE;
          end
        end
      end
      S_LOCK: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_load) begin
    if (!reset_load) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_load) begin
    if (!reset_load) begin
      r_x      <= 8'd0;
      r_y      <= 7'(SCREEN_H - STEP);
      r_h      <= 1'b1;
      r_cnt    <= '0;
      r_period <= c_CNT_W'(BASE_PERIOD);
      r_rlim   <= 8'(SCREEN_W - STEP);
      r_done   <= 1'b0;
      r_sv     <= 1'b0;
      r_sx     <= 8'd0;
      r_top    <= 1'b0;
    end else begin
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_h      <= w_h_nxt;
      r_cnt    <= w_cnt_nxt;
      r_period <= w_period_nxt;
      r_rlim   <= w_rlim_nxt;
      r_done   <= w_done_nxt;
      r_sv     <= w_sv_nxt;
      r_sx     <= w_sx_nxt;
      r_top    <= w_top;
    end
  end

  assign x             = r_x;
  assign y             = r_y;
  assign horizontal    = r_h;
  assign done_load     = r_done;
  assign stopped_valid = r_sv;
  assign stopped_x     = r_sx;
  assign busy          = (r_state == S_MOVE);
  assign top_reached   = r_top;
  assign colour        = colour_erase_enable ? 3'b000 : colour_in;

endmodule
`default_nettype wire

// File: tb/tb_block_mover.sv
`default_nettype none
// ============================================================================
//  Module      : tb_block_mover
//  Description : Directed self-checking bench for block_mover. Runs a bounce
//                instance and a wrap instance side by side on the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_block_mover;

  logic       clk;
  logic       reset_load;
  logic       tick, start, stop;
  logic [5:0] level_in;
  logic [2:0] block_cells, colour_in;
  logic       colour_erase_enable;

  logic [7:0] x, stopped_x, xw, stopped_xw;
  logic [6:0] y, yw;
  logic [2:0] colour, colourw;
  logic       horizontal, done_load, stopped_valid, busy, top_reached;
  logic       horizontalw, done_loadw, stopped_validw, busyw, top_reachedw;

  int n_checks = 0;
  int n_fail   = 0;
  int dl_cnt   = 0;

  block_mover #(.BASE_PERIOD(4), .WRAP(0)) u_dut (
    .clk(clk), .reset_load(reset_load), .tick(tick), .start(start), .stop(stop),
    .level_in(level_in), .block_cells(block_cells), .colour_in(colour_in),
    .colour_erase_enable(colour_erase_enable),
    .x(x), .y(y), .colour(colour), .horizontal(horizontal), .done_load(done_load),
    .stopped_valid(stopped_valid), .stopped_x(stopped_x), .busy(busy),
    .top_reached(top_reached)
  );

  block_mover #(.BASE_PERIOD(4), .WRAP(1)) u_dut_wrap (
    .clk(clk), .reset_load(reset_load), .tick(tick), .start(start), .stop(stop),
    .level_in(level_in), .block_cells(block_cells), .colour_in(colour_in),
    .colour_erase_enable(colour_erase_enable),
    .x(xw), .y(yw), .colour(colourw), .horizontal(horizontalw), .done_load(done_loadw),
    .stopped_valid(stopped_validw), .stopped_x(stopped_xw), .busy(busyw),
    .top_reached(top_reachedw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done_load) dl_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
    end
    tick = 1'b0;
  endtask

  task automatic do_start(input logic [5:0] lvl, input logic [2:0] cells);
    level_in    = lvl;
    block_cells = cells;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_load = 1'b0;
    tick = 1'b0; start = 1'b0; stop = 1'b0;
    level_in = '0; block_cells = 3'd1;
    colour_in = 3'd5; colour_erase_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    check_eq("rst_x", x, 0);
    check_eq("rst_y", y, 116);
    check_eq("rst_h", horizontal, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done_load, 0);
    check_eq("rst_sv", stopped_valid, 0);
    check_eq("rst_sx", stopped_x, 0);
    check_eq("rst_top", top_reached, 0);
    check_eq("rst_wrap_y", yw, 116);
    check_eq("colour_pass", colour, 5);
    colour_erase_enable = 1'b1;
    #1;
    check_eq("colour_erase", colour, 0);
    colour_erase_enable = 1'b0;
    @(negedge clk);
    reset_load = 1'b1;
    @(negedge clk);

    // Stop in IDLE is ignored
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_eq("idle_stop_sv", stopped_valid, 0);
    check_eq("idle_stop_busy", busy, 0);

    // Level 0, one cell, bounce sweep
    do_start(6'd0, 3'd1);
    check_eq("start_done", done_load, 1);
    check_eq("start_x", x, 0);
    check_eq("start_y", y, 116);
    check_eq("start_busy", busy, 1);
    check_eq("start_h", horizontal, 1);
    @(negedge clk);
    check_eq("start_done_1cyc", done_load, 0);
    do_ticks(3);
    check_eq("three_ticks_x", x, 0);
    do_ticks(1);
    check_eq("fourth_tick_x", x, 4);
    check_eq("fourth_tick_done", done_load, 1);
    check_eq("wrap_x4", xw, 4);
    do_ticks(152);
    check_eq("right_edge_x", x, 156);
    check_eq("right_edge_h", horizontal, 1);
    check_eq("wrap_x156", xw, 156);
    do_ticks(4);
    check_eq("bounce_r_x", x, 152);
    check_eq("bounce_r_h", horizontal, 0);
    check_eq("wrap_to0_x", xw, 0);
    check_eq("wrap_to0_h", horizontalw, 1);
    do_ticks(152);
    check_eq("left_edge_x", x, 0);
    check_eq("left_edge_h", horizontal, 0);
    check_eq("wrap_x152", xw, 152);
    do_ticks(4);
    check_eq("bounce_l_x", x, 4);
    check_eq("bounce_l_h", horizontal, 1);
    do_ticks(36);
    check_eq("pre_stop_x", x, 40);
    check_eq("pre_stop_wrap_x", xw, 32);

    // Stop in the same cycle as a due move
    do_ticks(3);
    check_eq("almost_due_x", x, 40);
    tick = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    stop = 1'b0;
    check_eq("lock_sv", stopped_valid, 1);
    check_eq("lock_sx", stopped_x, 40);
    check_eq("lock_x", x, 40);
    check_eq("lock_done", done_load, 0);
    check_eq("lock_busy", busy, 0);
    check_eq("lock_wrap_sx", stopped_xw, 32);
    @(negedge clk);
    check_eq("post_lock_sv", stopped_valid, 0);
    check_eq("post_lock_sx", stopped_x, 40);
    check_eq("post_lock_x", x, 40);
    check_eq("post_lock_busy", busy, 0);
    check_eq("done_pulse_count", dl_cnt, 89);

    // Three cells: right limit 148; width change mid-move has no effect
    do_start(6'd0, 3'd3);
    check_eq("c3_start_x", x, 0);
    block_cells = 3'd1;
    do_ticks(144);
    check_eq("c3_x144", x, 144);
    do_ticks(4);
    check_eq("c3_x148", x, 148);
    check_eq("c3_wrap_x148", xw, 148);
    do_ticks(4);
    check_eq("c3_bounce_x", x, 144);
    check_eq("c3_bounce_h", horizontal, 0);
    check_eq("c3_wrap_x0", xw, 0);
    check_eq("c3_wrap_h", horizontalw, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("move_start_ign_x", x, 144);
    check_eq("move_start_ign_done", done_load, 0);
    do_stop();

    // Level 10: period 1, y = 76; level change mid-move has no effect
    do_start(6'd10, 3'd1);
    check_eq("l10_y", y, 76);
    check_eq("l10_x", x, 0);
    do_ticks(1);
    check_eq("l10_tick1_x", x, 4);
    check_eq("l10_tick1_done", done_load, 1);
    level_in = 6'd0;
    do_ticks(1);
    check_eq("l10_tick2_x", x, 8);
    check_eq("l10_hold_y", y, 76);
    do_stop();

    // Top-of-screen boundary
    level_in = 6'd29;
    @(negedge clk);
    check_eq("l29_top", top_reached, 0);
    level_in = 6'd30;
    @(negedge clk);
    check_eq("l30_top", top_reached, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("l30_busy", busy, 0);
    check_eq("l30_done", done_load, 0);

    // Asynchronous reset mid-move at x = 80
    do_start(6'd0, 3'd1);
    do_ticks(80);
    check_eq("pre_rst_x", x, 80);
    @(posedge clk);
    #2;
    reset_load = 1'b0;
    #1;
    check_eq("arst_x", x, 0);
    check_eq("arst_y", y, 116);
    check_eq("arst_h", horizontal, 1);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_sx", stopped_x, 0);
    check_eq("arst_wrap_x", xw, 0);
    @(negedge clk);
    check_eq("arst_sv", stopped_valid, 0);
    check_eq("arst_done", done_load, 0);
    reset_load = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/block_mover.md
Name: block_mover

Overview:
- Registered, parametrised successor to the block-stacker position loader.
- Sweeps a multi-cell block horizontally across the VGA grid, one row per level, at a level-dependent speed.
- Supports bounce or wrap motion, and latches the block's position when the player presses stop.
- Feeds x/y/colour to the draw/erase datapath and the stop position to the stack-overlap logic.

Parameters:
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- STEP, 4, pixels per cell and per move (cell is STEP×STEP).
- MAX_CELLS, 4, maximum block width in cells.
- LEVEL_W, 6, width of the level input.
- BASE_PERIOD, 8, ticks between moves at level 0 (minimum 1).
- WRAP, 0, motion mode: 0 = bounce at edges, 1 = wrap right edge to x=0.

Ports:
- clk  input  1  system clock.
- reset_load  input  1  reset: one clock; reset is asynchronous and active-low.
- tick  input  1  one-cycle frame/timebase pulse.
- start  input  1  begin sweeping at the current level_in (sampled in IDLE only).
- stop  input  1  player stop request (sampled in MOVE only).
- level_in  input  LEVEL_W  current level, 0 = bottom row.
- block_cells  input  3  block width in cells, 1..MAX_CELLS; sampled at start.
- colour_in  input  3  draw colour.
- colour_erase_enable  input  1  force colour to black.
- x  output  8  left-edge pixel of the block.
- y  output  7  top pixel of the block row.
- colour  output  3  draw colour.
- horizontal  output  1  direction: 1 = right, 0 = left.
- done_load  output  1  one-cycle pulse: new x/y valid.
- stopped_valid  output  1  one-cycle pulse: block locked.
- stopped_x  output  8  x at lock; held until next lock.
- busy  output  1  high in MOVE.
- top_reached  output  1  level_in row is above the screen; start refused.

Behaviour:
- Reset (async, reset_load=0): state IDLE, x=0, y=SCREEN_H-STEP (116), horizontal=1, tick counter=0. All pulse outputs are 0 and remain 0 until the next event. stopped_x=0, busy=0, top_reached=0.
- Geometry:
  - cells = clamp(block_cells, 1, MAX_CELLS), latched at start.
  - right limit R = SCREEN_W - STEP·cells.
  - y = SCREEN_H - STEP·(level+1); arithmetic is done at ≥9 bits.
  - If level+1 > SCREEN_H/STEP, top_reached=1, start is ignored, and the FSM stays in IDLE.
- Speed: period = (BASE_PERIOD > level) ? BASE_PERIOD - level : 1, latched at start.
- States:
  - IDLE: busy=0. On start (and !top_reached) → MOVE, with x=0, horizontal=1, y from level, counter=0, and done_load pulsed on the entry edge.
  - MOVE: busy=1. Each tick increments the counter. When a tick arrives with counter==period-1, the counter clears and one move happens on that edge.
  - LOCK: entered on stop. For one cycle stopped_valid=1 and stopped_x=x. Then → IDLE unconditionally. x and y hold their values.
- Move rule, bounce mode (WRAP=0):
  - Moving right: x==R → horizontal=0, x=R-STEP; otherwise x+=STEP.
  - Moving left: x==0 → horizontal=1, x=STEP; otherwise x-=STEP.
- Move rule, wrap mode (WRAP=1): horizontal stays 1; x==R → x=0; otherwise x+=STEP.
- Degenerate width: if R==0 (block spans the screen), x stays 0 and no direction change occurs, but done_load still pulses on each due move.
- done_load: high for exactly the one cycle in which updated x/y first appear.
- Simultaneous events:
  - stop with a due move in the same cycle: stop wins, no move, stopped_x = pre-move x, no done_load.
  - start in MOVE/LOCK is ignored; stop in IDLE is ignored.
  - level_in/block_cells changes during MOVE have no effect.
- colour = colour_erase_enable ? 3'b000 : colour_in, combinational in all states.
- Reset mid-MOVE or mid-LOCK aborts immediately to the reset values; no stopped_valid is emitted.

Test Plan:
- Reset with x forced mid-sweep → x=0, y=116, horizontal=1, busy=0, no pulses.
- BASE_PERIOD=4, level 0, cells=1, start, 4 ticks → x=4, one done_load pulse; continue → x reaches 156, next move x=152, horizontal=0; at x=0 next move x=4, horizontal=1.
- cells=3 → R=148; sequence 144→148→144 with direction flip; WRAP=1 build: 148→0, horizontal stays 1.
- At x=40, stop asserted in the same cycle as the due move → stopped_valid one cycle, stopped_x=40, x stays 40, no done_load, then IDLE.
- Level 10, BASE_PERIOD=4 → period 1, a move on every tick, y=76. Level 30 → top_reached=1, start ignored, busy stays 0.
- reset_load dropped asynchronously at x=80 mid-MOVE → outputs return to reset values before the next clk edge; no stopped_valid.
